power_accum: RTL and testbench

- Consumer end of the column-power stream from the |x|^2 stage.
- Accumulates 4-lane power columns (two columns per beat, addressed by column index) over 2^frames_log2 FFT frames into an internal accumulator array.
- After the last frame, dumps the array over a valid/ready stream for downstream peak search or readout.

---
 rtl/power_accum_pkg.sv | 28 ++
 rtl/power_accum_lane_add.sv | 21 ++
 rtl/power_accum.sv | 225 ++++++++++++++++++++++
 tb/tb_power_accum.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_accum_pkg.sv
// Shared widths, FSM state type and row types for the power accumulator.
// Also holds the rounding helper used when POWER_ACCUM_AVG_EN is defined.
package power_accum_pkg;
  localparam int unsigned LANES           = 4;
  localparam int unsigned IDX_W           = 11;
  localparam int unsigned DATA_WIDTH      = 53;
  localparam int unsigned ACC_WIDTH       = 64;
  localparam int unsigned NUM_COLS        = 2048;
  localparam int unsigned BEATS_PER_FRAME = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;
  typedef logic [LANES-1:0][ACC_WIDTH-1:0]  acc_row_t;

  // Round-half-up average of one lane over 2^sh frames.
  function automatic logic [ACC_WIDTH-1:0] avg_lane(input logic [ACC_WIDTH-1:0] acc,
                                                    input logic [2:0] sh);
    logic [ACC_WIDTH:0] t;
    t = {1'b0, acc};
    if (sh != 3'd0) t = t + ((ACC_WIDTH+1)'(1) << (sh - 3'd1));
    return ACC_WIDTH'(t >> sh);
  endfunction
endpackage

// File: rtl/power_accum_lane_add.sv
// One lane: clamp negative input to zero, zero-extend, then either load
// (first frame) or add with saturation to the accumulator value.
module power_accum_lane_add
  import power_accum_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] lane,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic                  first,
  output logic [ACC_WIDTH-1:0]  sum_c
);
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   raw;

  always_comb begin
    ext = lane[DATA_WIDTH-1] ? '0 : ACC_WIDTH'(lane);
    raw = {1'b0, acc} + {1'b0, ext};
    if (first)               sum_c = ext;
    else if (raw[ACC_WIDTH]) sum_c = '1;
    else                     sum_c = raw[ACC_WIDTH-1:0];
  end
endmodule

// File: rtl/power_accum.sv
// Column-power accumulator: read-modify-write over 2^frames_log2 frames, then
// dumps all rows over valid/ready. POWER_ACCUM_AVG_EN adds a rounding average stage.
module power_accum
  import power_accum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       frames_log2,
  input  logic             in_valid,
  input  lane_vec_t        in_col1,
  input  lane_vec_t        in_col2,
  input  logic [IDX_W-1:0] in_index_col1,
  input  logic [IDX_W-1:0] in_index_col2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output acc_row_t         out_data,
  output logic             busy,
  output logic             done,
  output logic             drop_err
);
  localparam int unsigned BEAT_W  = $clog2(BEATS_PER_FRAME);
  localparam int unsigned FRAME_W = 8;

  state_t            state, state_next;
  logic [2:0]        fl2;
  logic [BEAT_W-1:0] beat_cnt;
  logic [FRAME_W-1:0] frame_cnt, frame_last_c;
  logic              drain, drain_cnt;
  logic              accept_c, last_beat_c, drain_done_c, xfer_last_c;

  acc_row_t          mem [NUM_COLS];

  logic              s1_valid, s1_b_en, s1_first, b_en_c;
  logic [IDX_W-1:0]  s1_idx_a, s1_idx_b;
  lane_vec_t         s1_in_a, s1_in_b;
  acc_row_t          s1_rd_a, s1_rd_b, rd_a_c, rd_b_c, sum_a_c, sum_b_c;

  logic [IDX_W:0]    rd_addr;
  logic              rd_avail_c, adv_out_c;

  assign frame_last_c = ~({FRAME_W{1'b1}} << fl2);
  assign b_en_c       = (in_index_col1 > IDX_W'(1)) && (in_index_col2 != in_index_col1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (drain_done_c) state_next = DUMP;
      DUMP:    if (xfer_last_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_c     = 1'b0;
    last_beat_c  = 1'b0;
    drain_done_c = 1'b0;
    xfer_last_c  = 1'b0;
    case (state)
      ACCUM: begin
        accept_c     = in_valid && !drain;
        last_beat_c  = accept_c && (beat_cnt == BEAT_W'(BEATS_PER_FRAME-1))
                       && (frame_cnt == frame_last_c);
        drain_done_c = drain && drain_cnt;
      end
      DUMP:    xfer_last_c = out_valid && out_ready && (out_index == IDX_W'(NUM_COLS-1));
      default: ;
    endcase
  end

  // Run control: counters, drain timer, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl2       <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      drain     <= 1'b0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= xfer_last_c;
      if (state == IDLE && start) begin
        fl2       <= frames_log2;
        beat_cnt  <= '0;
        frame_cnt <= '0;
        drain     <= 1'b0;
        drain_cnt <= 1'b0;
        drop_err  <= 1'b0;
      end else begin
        if (in_valid && state != ACCUM) drop_err <= 1'b1;
        if (accept_c) begin
          if (beat_cnt == BEAT_W'(BEATS_PER_FRAME-1)) begin
            beat_cnt  <= '0;
            frame_cnt <= frame_cnt + FRAME_W'(1);
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        if (last_beat_c) drain <= 1'b1;
        if (drain) drain_cnt <= 1'b1;
      end
    end
  end

  // Read stage with forwarding from the write stage (newest write wins).
  always_comb begin
    rd_a_c = mem[in_index_col1];
    if (s1_valid && s1_b_en && s1_idx_b == in_index_col1) rd_a_c = sum_b_c;
    if (s1_valid && s1_idx_a == in_index_col1)            rd_a_c = sum_a_c;
    rd_b_c = mem[in_index_col2];
    if (s1_valid && s1_b_en && s1_idx_b == in_index_col2) rd_b_c = sum_b_c;
    if (s1_valid && s1_idx_a == in_index_col2)            rd_b_c = sum_a_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_b_en  <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      s1_b_en  <= accept_c && b_en_c;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      s1_idx_a <= in_index_col1;
      s1_idx_b <= in_index_col2;
      s1_in_a  <= in_col1;
      s1_in_b  <= in_col2;
      s1_first <= (frame_cnt == '0);
      s1_rd_a  <= rd_a_c;
      s1_rd_b  <= rd_b_c;
    end
  end

  for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
    power_accum_lane_add u_add_a (
      .lane(s1_in_a[ln]), .acc(s1_rd_a[ln]), .first(s1_first), .sum_c(sum_a_c[ln])
    );
    power_accum_lane_add u_add_b (
      .lane(s1_in_b[ln]), .acc(s1_rd_b[ln]), .first(s1_first), .sum_c(sum_b_c[ln])
    );
  end

  // Write stage; a reset edge abandons the in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && s1_valid) begin
      mem[s1_idx_a] <= sum_a_c;
      if (s1_b_en) mem[s1_idx_b] <= sum_b_c;
    end
  end

  assign rd_avail_c = (state == DUMP) && !rd_addr[IDX_W];
  assign adv_out_c  = !out_valid || out_ready;

`ifdef POWER_ACCUM_AVG_EN
  logic             mid_valid, adv_mid_c;
  logic [IDX_W-1:0] mid_index;
  acc_row_t         mid_data, avg_c;

  assign adv_mid_c = !mid_valid || adv_out_c;

  always_comb begin
    for (int l = 0; l < LANES; l++) avg_c[l] = avg_lane(mid_data[l], fl2);
  end

  // Two-deep dump pipeline: registered read, then averaging output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid <= 1'b0;
      mid_index <= '0;
      mid_data  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      rd_addr   <= '0;
    end else if (state != DUMP) begin
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
      rd_addr   <= '0;
    end else begin
      if (adv_mid_c) begin
        mid_valid <= rd_avail_c;
        mid_index <= rd_addr[IDX_W-1:0];
        mid_data  <= mem[rd_addr[IDX_W-1:0]];
        if (rd_avail_c) rd_addr <= rd_addr + (IDX_W+1)'(1);
      end
      if (adv_out_c) begin
        out_valid <= mid_valid;
        out_index <= mid_index;
        out_data  <= avg_c;
      end
    end
  end
`else
  // Registered read straight into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      rd_addr   <= '0;
    end else if (state != DUMP) begin
      out_valid <= 1'b0;
      rd_addr   <= '0;
    end else if (adv_out_c) begin
      out_valid <= rd_avail_c;
      out_index <= rd_addr[IDX_W-1:0];
      out_data  <= mem[rd_addr[IDX_W-1:0]];
      if (rd_avail_c) rd_addr <= rd_addr + (IDX_W+1)'(1);
    end
  end
`endif
endmodule

// File: tb/tb_power_accum.sv
// Randomized bench for power_accum against a row-level reference model
// of the accumulate/saturate/dump rules.
module tb_power_accum;
  import power_accum_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready;
  logic [2:0]       frames_log2;
  lane_vec_t        in_col1, in_col2;
  logic [IDX_W-1:0] in_index_col1, in_index_col2;
  logic             out_valid, busy, done, drop_err;
  logic [IDX_W-1:0] out_index;
  acc_row_t         out_data;

  int       checks = 0;
  int       errors = 0;
  acc_row_t model [NUM_COLS];
  bit       known [NUM_COLS];

  always #5 clk = ~clk;

  power_accum dut (
    .clk(clk), .rst(rst), .start(start), .frames_log2(frames_log2),
    .in_valid(in_valid), .in_col1(in_col1), .in_col2(in_col2),
    .in_index_col1(in_index_col1), .in_index_col2(in_index_col2),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .busy(busy), .done(done), .drop_err(drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one column update on the model.
  task automatic apply(input int idx, input lane_vec_t v, input bit first);
    logic [ACC_WIDTH-1:0] c, maxv;
    maxv = '1;
    for (int l = 0; l < LANES; l++) begin
      c = v[l][DATA_WIDTH-1] ? '0 : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v[l]};
      if (first)                      model[idx][l] = c;
      else if (maxv - model[idx][l] < c) model[idx][l] = maxv;
      else                            model[idx][l] = model[idx][l] + c;
    end
    if (first) known[idx] = 1'b1;
  endtask

  function automatic acc_row_t expect_row(input int r, input int fl2);
    acc_row_t e;
`ifdef POWER_ACCUM_AVG_EN
    logic [ACC_WIDTH-1:0] q, rem, msk;
    for (int l = 0; l < LANES; l++) begin
      q   = model[r][l] >> fl2;
      msk = ~({ACC_WIDTH{1'b1}} << fl2);
      rem = model[r][l] & msk;
      if (fl2 > 0 && rem >= (ACC_WIDTH'(1) << (fl2 - 1))) q = q + ACC_WIDTH'(1);
      e[l] = q;
    end
`else
    e = model[r];
    if (fl2 < 0) e = '0;
`endif
    return e;
  endfunction

  function automatic lane_vec_t rand_lanes();
    lane_vec_t v;
    for (int l = 0; l < LANES; l++) begin
      v[l] = DATA_WIDTH'({$urandom, $urandom});
      v[l][DATA_WIDTH-1] = ($urandom_range(3) == 0);
    end
    return v;
  endfunction

  task automatic run_accum(input int fl2, input int mode, input int gap_pct);
    logic [IDX_W-1:0] ia, ib, pa, pb;
    lane_vec_t va, vb;
    pa = '0;
    pb = '0;
    start = 1'b1;
    frames_log2 = 3'(fl2);
    tick();
    start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
    check("drop_err_cleared", 256'(drop_err), 256'(0));
    for (int f = 0; f < (1 << fl2); f++) begin
      for (int b = 0; b < int'(BEATS_PER_FRAME); b++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          in_valid = 1'b0;
          tick();
        end
        if (b == 0)      begin ia = 11'd2; ib = 11'd0; end
        else if (b == 1) begin ia = 11'd3; ib = 11'd1; end
        else             begin ia = IDX_W'(2*b); ib = IDX_W'(2*b + 1); end
        case (mode)
          0: for (int l = 0; l < LANES; l++) begin
               va[l] = DATA_WIDTH'(ia);
               vb[l] = DATA_WIDTH'(ib);
             end
          1: for (int l = 0; l < LANES; l++) begin
               va[l] = DATA_WIDTH'(5);
               vb[l] = DATA_WIDTH'(5);
             end
          2: begin
               va = rand_lanes();
               vb = rand_lanes();
               if (f == 0) begin
                 if (ia == 11'd7 || ia == 11'd8) va = '0;
                 if (ib == 11'd7 || ib == 11'd8) vb = '0;
               end else if (b < 3) begin
                 ia = 11'd7; ib = 11'd8;
                 for (int l = 0; l < LANES; l++) begin va[l] = 53'd1; vb[l] = 53'd1; end
               end else if (b == 3) begin
                 ia = 11'd2; ib = 11'd2;
                 for (int l = 0; l < LANES; l++) begin va[l] = 53'd4; vb[l] = 53'd4; end
               end else if (b == 4) begin
                 ia = 11'd1; ib = 11'd100;
                 for (int l = 0; l < LANES; l++) begin va[l] = 53'd9; vb[l] = 53'd9; end
               end else begin
                 ia = IDX_W'($urandom_range(2047, 200));
                 ib = IDX_W'($urandom_range(2047, 200));
                 if (b > 5) begin
                   case ($urandom_range(3))
                     0: ia = pa;
                     1: begin ia = pb; ib = pa; end
                     default: ;
                   endcase
                 end
               end
             end
          default: begin
               ia = 11'd5; ib = 11'd6;
               va[0] = 53'h0F_FFFF_FFFF_FFFF;
               va[1] = 53'd3;
               va[2] = 53'h10_0000_0000_0001;
               va[3] = 53'h0F_FFFF_FFFF_FFFE;
               vb = va;
               vb[1] = 53'd7;
             end
        endcase
        in_valid = 1'b1;
        in_index_col1 = ia;
        in_index_col2 = ib;
        in_col1 = va;
        in_col2 = vb;
        apply(int'(ia), va, f == 0);
        if (ia > 11'd1 && ib != ia) apply(int'(ib), vb, f == 0);
        pa = ia;
        pb = ib;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_dump(input int fl2, input bit toggle, input int abort_at);
    int row = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [IDX_W-1:0] h_idx;
    acc_row_t h_data;
    h_idx = '0;
    h_data = '0;
    while (row < int'(NUM_COLS) && cyc < 20000 && !(abort_at >= 0 && row == abort_at)) begin
      if (held) begin
        check("stall_valid", 256'(out_valid), 256'(1));
        check("stall_index", 256'(out_index), 256'(h_idx));
        check("stall_data", out_data, h_data);
      end
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (out_valid && out_ready) begin
        check("dump_index", 256'(out_index), 256'(row));
        if (known[row]) check("dump_data", out_data, expect_row(row, fl2));
        row++;
      end
      held  = out_valid && !out_ready;
      h_idx = out_index;
      h_data = out_data;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    if (abort_at >= 0) begin
      check("abort_reached", 256'(row), 256'(abort_at));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_out_valid", 256'(out_valid), 256'(0));
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_done", 256'(done), 256'(0));
      tick();
    end else begin
      check("dump_rows", 256'(row), 256'(NUM_COLS));
      check("done_pulse", 256'(done), 256'(1));
      check("done_out_valid", 256'(out_valid), 256'(0));
      check("done_busy", 256'(busy), 256'(0));
      tick();
      check("done_one_cycle", 256'(done), 256'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_COLS); i++) begin
      known[i] = 1'b0;
      model[i] = '0;
    end
    rst = 1'b1;
    start = 1'b0;
    frames_log2 = '0;
    in_valid = 1'b0;
    in_col1 = '0;
    in_col2 = '0;
    in_index_col1 = '0;
    in_index_col2 = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_drop_err", 256'(drop_err), 256'(0));
    check("rst_out_index", 256'(out_index), 256'(0));
    check("rst_out_data", out_data, 256'(0));
    rst = 1'b0;
    tick();

    // Beat while idle sets the sticky drop flag.
    in_valid = 1'b1;
    in_col1 = rand_lanes();
    tick();
    in_valid = 1'b0;
    check("drop_err_set", 256'(drop_err), 256'(1));
    tick();
    check("drop_err_sticky", 256'(drop_err), 256'(1));

    run_accum(0, 0, 0);
    run_dump(0, 1'b0, -1);

    run_accum(2, 1, 10);
    run_dump(2, 1'b0, -1);

    run_accum(1, 2, 30);
    run_dump(1, 1'b1, -1);

    run_accum(3, 3, 0);
    run_dump(3, 1'b1, -1);

    run_accum(0, 1, 0);
    run_dump(0, 1'b0, 300);

    run_accum(0, 0, 5);
    run_dump(0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
